insn_control: RTL and testbench
===============================

Name: insn_control

Overview:
- Instruction sequencer/decoder for the 4-bit CPU datapath. It is the producer side of the ALU control interface: it drives alu_op, alu_in0_sel, alu_in1_sel and alu_cin_sel.
- Runs the 8-phase instruction cycle (A1 A2 A3 M1 M2 X1 X2 X3) and latches the two instruction nibbles from the ROM bus.
- Decodes them into ALU selects plus accumulator, carry, register and PC write strobes. Handles two-word jumps.

Parameters:
- NUM_REGS, 16, index registers addressed by OPA; reg_addr width is $clog2(NUM_REGS).

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- rom_data  in  4  nibble bus from ROM, sampled at the end of M1 (OPR) and end of M2 (OPA)
- phase  out  3  current phase, A1=0 … X3=7
- sync  out  1  high during A1
- pc_inc  out  1  one-cycle pulse in M2 of every instruction cycle
- pc_load  out  1  one-cycle pulse in X3 of a JUN second word
- pc_target  out  12  {jun_opa, word2_opr, word2_opa}, valid when pc_load
- imm  out  4  latched OPA, drives the ALU data input
- reg_addr  out  4  latched OPA
- alu_op  out  3  ALU_OP_* code
- alu_in0_sel  out  3  ALU_IN0_* code
- alu_in1_sel  out  2  ALU_IN1_* code
- alu_cin_sel  out  2  ALU_CIN_* code
- acc_we  out  1  accumulator <= alu result[3:0], X3 only
- carry_we  out  1  carry <= alu result[4], X3 only
- reg_we  out  1  reg[reg_addr] <= reg_src value, X3 only
- reg_src  out  1  0 = alu result[3:0], 1 = acc (pre-update value)

Behaviour:
- Reset (async, reset_n low):
  - phase=A1; opr=opa=0 (NOP); second_word=0.
  - All strobes low.
  - Selects equal the NOP defaults: ALU_OP_PASS, ALU_IN0_ACC, ALU_IN1_ACC, ALU_CIN_CARRY.
- First rising edge after release enters A2.
- Phase counter is free-running mod 8; X3 wraps to A1.
- OPR register loads rom_data on the clock edge ending M1; OPA loads on the edge ending M2.
- Selects are combinational from the latched opr/opa and are stable X1–X3. Values outside X phases are don't-care but deterministic.
- Write enables are asserted only when phase==X3, for exactly one cycle.
- Decode (first word):
  - 0x00 NOP: no strobes.
  - 0x6r INC: in0 REG, in1 ONE, cin ZERO, ADD; reg_we, reg_src=0.
  - 0x8r ADD: in0 REG, in1 ACC, cin CARRY, ADD; acc_we, carry_we.
  - 0x9r SUB: in0 REG_INV, in1 ACC, cin CARRY_INV, ADD; acc_we, carry_we.
  - 0xAr LD: in0 REG, PASS; acc_we only.
  - 0xBr XCH: in0 REG, PASS; acc_we, reg_we, reg_src=1.
  - 0xDd LDM: in0 DATA, PASS; acc_we.
  - 0xF0 CLB: in0 ACC_INV, in1 ACC, cin ONE, ADD. Result is 0x10, so the ALU_CIN_* encoding is used with in0 DATA_INV and imm forced to 0xF via a PASS path instead. Required result: acc=0, carry=0; acc_we, carry_we.
  - 0xF1 CLC: PASS, cin ZERO; carry_we.
  - 0xF2 IAC: in0 ACC, in1 ONE, cin ZERO, ADD; acc_we, carry_we.
  - 0xF3 CMC: PASS, cin CARRY_INV; carry_we.
  - 0xF4 CMA: in0 ACC_INV, PASS; acc_we.
  - 0xF5 RAL: in0 ACC, cin CARRY, ROL; acc_we, carry_we.
  - 0xF6 RAR: ROR, same selects as RAL; acc_we, carry_we.
  - 0xF8 DAC: in0 ACC, in1 ONE_INV, cin ONE, ADD; acc_we, carry_we.
  - 0xFA STC: PASS, cin ONE; carry_we.
  - 0x4a JUN: no strobes; sets second_word at X3; opa saved as jun_opa.
  - All other codes: NOP.
- Second word (second_word=1):
  - M1/M2 latch the word into word2 registers and leave opr/opa untouched.
  - No decode; all ALU strobes low; pc_inc still pulses.
  - pc_load pulses at X3; second_word clears at the same X3.
- Reset mid-instruction: all state is abandoned and no strobe fires; the next cycle restarts at A1.
- sync, pc_inc and pc_load are registered-output clean (no glitch), derived from phase.

Decomposition:
- Phase constants (PH_A1..PH_X3) and opcode constants (OPR_INC, OPR_ADD, …, OPA_CLB…) are added to the shared datapath.vh next to the existing ALU_* select encodings, which this block reuses unchanged.
- One natural combinational sub-module, insn_decode: maps {opr, opa} to selects and write-enable intents. insn_control gates those intents with X3 and second_word.

Test Plan:
- Reset held for 3 cycles, then released -> phase 0→1, all strobes 0, selects at NOP defaults; sync high only in A1.
- Instruction 0x83 (ADD R3) -> in X1–X3: alu_op=ADD, in0=REG, in1=ACC, cin=CARRY, reg_addr=3; acc_we=carry_we=1 only in X3.
- Instruction 0xB5 (XCH R5) -> in X3: acc_we=1, reg_we=1, reg_src=1, reg_addr=5, alu_op=PASS, in0=REG.
- JUN 0x4A then 0x7C -> first cycle: no strobes. Second cycle: pc_inc in M2, pc_load in X3 with pc_target=0xA7C. Third cycle decodes normally.
- Instruction 0xF6 (RAR) -> X3: alu_op=ROR, cin=CARRY, acc_we=carry_we=1. Unsupported 0xF7 -> no strobes.
- reset_n dropped in X2 of an ADD -> no acc_we/carry_we ever seen; after release phase restarts at A1 and opr=0.

Source files
------------

// File: rtl/insn_control_pkg.sv
// Shared encodings for the 4-bit CPU instruction sequencer and the ALU control interface.
package insn_control_pkg;

  // Instruction-cycle phases, A1 = 0 .. X3 = 7.
  typedef enum logic [2:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_e;

  // ALU operation; PASS yields {cin, in0}.
  localparam logic [2:0] ALU_OP_PASS = 3'd0;
  localparam logic [2:0] ALU_OP_ADD  = 3'd1;
  localparam logic [2:0] ALU_OP_ROL  = 3'd2;
  localparam logic [2:0] ALU_OP_ROR  = 3'd3;

  localparam logic [2:0] ALU_IN0_ACC      = 3'd0;
  localparam logic [2:0] ALU_IN0_ACC_INV  = 3'd1;
  localparam logic [2:0] ALU_IN0_REG      = 3'd2;
  localparam logic [2:0] ALU_IN0_REG_INV  = 3'd3;
  localparam logic [2:0] ALU_IN0_DATA     = 3'd4;
  localparam logic [2:0] ALU_IN0_DATA_INV = 3'd5;

  localparam logic [1:0] ALU_IN1_ACC     = 2'd0;
  localparam logic [1:0] ALU_IN1_ONE     = 2'd1;
  localparam logic [1:0] ALU_IN1_ONE_INV = 2'd2;
  localparam logic [1:0] ALU_IN1_ZERO    = 2'd3;

  localparam logic [1:0] ALU_CIN_CARRY     = 2'd0;
  localparam logic [1:0] ALU_CIN_CARRY_INV = 2'd1;
  localparam logic [1:0] ALU_CIN_ZERO      = 2'd2;
  localparam logic [1:0] ALU_CIN_ONE       = 2'd3;

  // First-nibble (OPR) opcodes.
  localparam logic [3:0] OPR_NOP = 4'h0;
  localparam logic [3:0] OPR_JUN = 4'h4;
  localparam logic [3:0] OPR_INC = 4'h6;
  localparam logic [3:0] OPR_ADD = 4'h8;
  localparam logic [3:0] OPR_SUB = 4'h9;
  localparam logic [3:0] OPR_LD  = 4'hA;
  localparam logic [3:0] OPR_XCH = 4'hB;
  localparam logic [3:0] OPR_LDM = 4'hD;
  localparam logic [3:0] OPR_ACC = 4'hF;

  // Accumulator-group (OPR = F) sub-opcodes in OPA.
  localparam logic [3:0] OPA_CLB = 4'h0;
  localparam logic [3:0] OPA_CLC = 4'h1;
  localparam logic [3:0] OPA_IAC = 4'h2;
  localparam logic [3:0] OPA_CMC = 4'h3;
  localparam logic [3:0] OPA_CMA = 4'h4;
  localparam logic [3:0] OPA_RAL = 4'h5;
  localparam logic [3:0] OPA_RAR = 4'h6;
  localparam logic [3:0] OPA_DAC = 4'h8;
  localparam logic [3:0] OPA_STC = 4'hA;

  // Decoded selects plus write intents (not yet gated by phase).
  typedef struct packed {
    logic [2:0] alu_op;
    logic [2:0] in0_sel;
    logic [1:0] in1_sel;
    logic [1:0] cin_sel;
    logic       acc_we;
    logic       carry_we;
    logic       reg_we;
    logic       reg_src;
    logic       is_jun;
    logic       force_imm;
  } decode_t;

endpackage

// File: rtl/insn_control_decode.sv
// Combinational instruction decoder: {opr, opa} -> ALU selects and write intents.
module insn_control_decode
  import insn_control_pkg::*;
(
  input  logic [3:0] opr,
  input  logic [3:0] opa,
  output decode_t    dec
);

  // Start from the NOP defaults, then override per opcode.
  always_comb begin
    dec         = '0;
    dec.alu_op  = ALU_OP_PASS;
    dec.in0_sel = ALU_IN0_ACC;
    dec.in1_sel = ALU_IN1_ACC;
    dec.cin_sel = ALU_CIN_CARRY;
    unique case (opr)
      OPR_JUN: dec.is_jun = 1'b1;
      OPR_INC: begin
        dec.in0_sel = ALU_IN0_REG;
        dec.in1_sel = ALU_IN1_ONE;
        dec.cin_sel = ALU_CIN_ZERO;
        dec.alu_op  = ALU_OP_ADD;
        dec.reg_we  = 1'b1;
      end
      OPR_ADD: begin
        dec.in0_sel  = ALU_IN0_REG;
        dec.alu_op   = ALU_OP_ADD;
        dec.acc_we   = 1'b1;
        dec.carry_we = 1'b1;
      end
      OPR_SUB: begin
        dec.in0_sel  = ALU_IN0_REG_INV;
        dec.cin_sel  = ALU_CIN_CARRY_INV;
        dec.alu_op   = ALU_OP_ADD;
        dec.acc_we   = 1'b1;
        dec.carry_we = 1'b1;
      end
      OPR_LD: begin
        dec.in0_sel = ALU_IN0_REG;
        dec.acc_we  = 1'b1;
      end
      OPR_XCH: begin
        dec.in0_sel = ALU_IN0_REG;
        dec.acc_we  = 1'b1;
        dec.reg_we  = 1'b1;
        dec.reg_src = 1'b1;
      end
      OPR_LDM: begin
        dec.in0_sel = ALU_IN0_DATA;
        dec.acc_we  = 1'b1;
      end
      OPR_ACC: begin
        unique case (opa)
          // Clear both via PASS of ~0xF with a zero carry-in.
          OPA_CLB: begin
            dec.in0_sel   = ALU_IN0_DATA_INV;
            dec.cin_sel   = ALU_CIN_ZERO;
            dec.force_imm = 1'b1;
            dec.acc_we    = 1'b1;
            dec.carry_we  = 1'b1;
          end
          OPA_CLC: begin
            dec.cin_sel  = ALU_CIN_ZERO;
            dec.carry_we = 1'b1;
          end
          OPA_IAC: begin
            dec.in1_sel  = ALU_IN1_ONE;
            dec.cin_sel  = ALU_CIN_ZERO;
            dec.alu_op   = ALU_OP_ADD;
            dec.acc_we   = 1'b1;
            dec.carry_we = 1'b1;
          end
          OPA_CMC: begin
            dec.cin_sel  = ALU_CIN_CARRY_INV;
            dec.carry_we = 1'b1;
          end
          OPA_CMA: begin
            dec.in0_sel = ALU_IN0_ACC_INV;
            dec.acc_we  = 1'b1;
          end
          OPA_RAL, OPA_RAR: begin
            dec.alu_op   = (opa == OPA_RAL) ? ALU_OP_ROL : ALU_OP_ROR;
            dec.acc_we   = 1'b1;
            dec.carry_we = 1'b1;
          end
          OPA_DAC: begin
            dec.in1_sel  = ALU_IN1_ONE_INV;
            dec.cin_sel  = ALU_CIN_ONE;
            dec.alu_op   = ALU_OP_ADD;
            dec.acc_we   = 1'b1;
            dec.carry_we = 1'b1;
          end
          OPA_STC: begin
            dec.cin_sel  = ALU_CIN_ONE;
            dec.carry_we = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/insn_control.sv
// Instruction sequencer: 8-phase cycle, ROM nibble latching, decode gating, two-word jumps.
module insn_control
  import insn_control_pkg::*;
#(
  parameter  int unsigned NUM_REGS = 16,
  localparam int unsigned RegW     = $clog2(NUM_REGS)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [3:0]      rom_data,
  output logic [2:0]      phase,
  output logic            sync,
  output logic            pc_inc,
  output logic            pc_load,
  output logic [11:0]     pc_target,
  output logic [3:0]      imm,
  output logic [RegW-1:0] reg_addr,
  output logic [2:0]      alu_op,
  output logic [2:0]      alu_in0_sel,
  output logic [1:0]      alu_in1_sel,
  output logic [1:0]      alu_cin_sel,
  output logic            acc_we,
  output logic            carry_we,
  output logic            reg_we,
  output logic            reg_src
);

  phase_e     phase_q, phase_d;
  logic [3:0] opr_q, opr_d, opa_q, opa_d;
  logic [3:0] w2_opr_q, w2_opr_d, w2_opa_q, w2_opa_d;
  logic [3:0] jun_opa_q, jun_opa_d;
  logic       second_q, second_d;
  logic       sync_q, sync_d, pc_inc_q, pc_inc_d, pc_load_q, pc_load_d;
  decode_t    dec;
  logic       x3_exec;

  insn_control_decode u_decode (
    .opr (opr_q),
    .opa (opa_q),
    .dec (dec)
  );

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q   <= PH_A1;
      opr_q     <= OPR_NOP;
      opa_q     <= 4'h0;
      w2_opr_q  <= 4'h0;
      w2_opa_q  <= 4'h0;
      jun_opa_q <= 4'h0;
      second_q  <= 1'b0;
      sync_q    <= 1'b1;
      pc_inc_q  <= 1'b0;
      pc_load_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      opr_q     <= opr_d;
      opa_q     <= opa_d;
      w2_opr_q  <= w2_opr_d;
      w2_opa_q  <= w2_opa_d;
      jun_opa_q <= jun_opa_d;
      second_q  <= second_d;
      sync_q    <= sync_d;
      pc_inc_q  <= pc_inc_d;
      pc_load_q <= pc_load_d;
    end
  end

  // Next phase, nibble latching, jump tracking and pre-registered phase pulses.
  always_comb begin
    phase_d   = phase_e'(phase_q + 3'd1);
    opr_d     = opr_q;
    opa_d     = opa_q;
    w2_opr_d  = w2_opr_q;
    w2_opa_d  = w2_opa_q;
    jun_opa_d = jun_opa_q;
    second_d  = second_q;
    if (phase_q == PH_M1) begin
      if (second_q) w2_opr_d = rom_data;
      else          opr_d    = rom_data;
    end
    if (phase_q == PH_M2) begin
      if (second_q) w2_opa_d = rom_data;
      else          opa_d    = rom_data;
    end
    if (phase_q == PH_X3) begin
      if (second_q) begin
        second_d = 1'b0;
      end else if (dec.is_jun) begin
        second_d  = 1'b1;
        jun_opa_d = opa_q;
      end
    end
    sync_d    = (phase_d == PH_A1);
    pc_inc_d  = (phase_d == PH_M2);
    pc_load_d = (phase_d == PH_X3) && second_q;
  end

  // Selects come straight from decode; write intents fire only in X3 of a first word.
  always_comb begin
    x3_exec     = (phase_q == PH_X3) && !second_q;
    phase       = phase_q;
    sync        = sync_q;
    pc_inc      = pc_inc_q;
    pc_load     = pc_load_q;
    pc_target   = {jun_opa_q, w2_opr_q, w2_opa_q};
    imm         = dec.force_imm ? 4'hF : opa_q;
    reg_addr    = opa_q[RegW-1:0];
    alu_op      = dec.alu_op;
    alu_in0_sel = dec.in0_sel;
    alu_in1_sel = dec.in1_sel;
    alu_cin_sel = dec.cin_sel;
    reg_src     = dec.reg_src;
    acc_we      = x3_exec && dec.acc_we;
    carry_we    = x3_exec && dec.carry_we;
    reg_we      = x3_exec && dec.reg_we;
  end

endmodule

// File: tb/tb_insn_control.sv
// Scoreboard bench for insn_control: architectural reference model plus an ALU model.
module tb_insn_control;
  import insn_control_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [3:0]  rom_data = 4'h0;
  logic [2:0]  phase;
  logic        sync, pc_inc, pc_load;
  logic [11:0] pc_target;
  logic [3:0]  imm, reg_addr;
  logic [2:0]  alu_op, alu_in0_sel;
  logic [1:0]  alu_in1_sel, alu_cin_sel;
  logic        acc_we, carry_we, reg_we, reg_src;

  insn_control #(.NUM_REGS(16)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rom_data    (rom_data),
    .phase       (phase),
    .sync        (sync),
    .pc_inc      (pc_inc),
    .pc_load     (pc_load),
    .pc_target   (pc_target),
    .imm         (imm),
    .reg_addr    (reg_addr),
    .alu_op      (alu_op),
    .alu_in0_sel (alu_in0_sel),
    .alu_in1_sel (alu_in1_sel),
    .alu_cin_sel (alu_cin_sel),
    .acc_we      (acc_we),
    .carry_we    (carry_we),
    .reg_we      (reg_we),
    .reg_src     (reg_src)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  typedef struct {
    logic [3:0]  opr, opa;
    logic        awe, cwe, rwe, pcl;
    logic [11:0] tgt;
    logic [3:0]  pre_acc, pre_reg, new_acc, new_reg;
    logic        pre_c, new_c;
  } exp_t;

  exp_t sb[$];

  // Architectural state of the reference CPU.
  logic [3:0] m_acc;
  logic       m_c;
  logic [3:0] m_regs[16];
  logic       m_second;
  logic [3:0] m_jun_opa;

  // Instruction semantics in plain arithmetic.
  task automatic predict(input logic [3:0] opr, input logic [3:0] opa, output exp_t e);
    int s;
    logic [3:0] nr;
    logic nc;
    e.opr = opr; e.opa = opa;
    e.awe = 1'b0; e.cwe = 1'b0; e.rwe = 1'b0; e.pcl = 1'b0; e.tgt = 12'h0;
    e.pre_acc = m_acc; e.pre_c = m_c; e.pre_reg = m_regs[opa];
    e.new_acc = m_acc; e.new_c = m_c; e.new_reg = m_regs[opa];
    nr = ~m_regs[opa];
    nc = ~m_c;
    s = 0;
    if (m_second) begin
      e.pcl = 1'b1;
      e.tgt = {m_jun_opa, opr, opa};
      m_second = 1'b0;
    end else begin
      case (opr)
        4'h4: begin m_second = 1'b1; m_jun_opa = opa; end
        4'h6: begin e.rwe = 1'b1; e.new_reg = m_regs[opa] + 4'd1; end
        4'h8: begin s = m_acc + m_regs[opa] + m_c; e.awe = 1; e.cwe = 1; end
        4'h9: begin s = m_acc + nr + nc; e.awe = 1; e.cwe = 1; end
        4'hA: begin e.awe = 1; e.new_acc = m_regs[opa]; end
        4'hB: begin e.awe = 1; e.rwe = 1; e.new_acc = m_regs[opa]; e.new_reg = m_acc; end
        4'hD: begin e.awe = 1; e.new_acc = opa; end
        4'hF: begin
          case (opa)
            4'h0: begin e.awe = 1; e.cwe = 1; e.new_acc = 4'h0; e.new_c = 1'b0; end
            4'h1: begin e.cwe = 1; e.new_c = 1'b0; end
            4'h2: begin s = m_acc + 1; e.awe = 1; e.cwe = 1; end
            4'h3: begin e.cwe = 1; e.new_c = ~m_c; end
            4'h4: begin e.awe = 1; e.new_acc = ~m_acc; end
            4'h5: begin e.awe = 1; e.cwe = 1; e.new_c = m_acc[3]; e.new_acc = {m_acc[2:0], m_c}; end
            4'h6: begin e.awe = 1; e.cwe = 1; e.new_c = m_acc[0]; e.new_acc = {m_c, m_acc[3:1]}; end
            4'h8: begin s = m_acc + 15; e.awe = 1; e.cwe = 1; end
            4'hA: begin e.cwe = 1; e.new_c = 1'b1; end
            default: ;
          endcase
          if (opa inside {4'h2, 4'h8}) begin e.new_acc = s[3:0]; e.new_c = s[4]; end
        end
        default: ;
      endcase
      if (opr inside {4'h8, 4'h9}) begin e.new_acc = s[3:0]; e.new_c = s[4]; end
      m_acc = e.new_acc;
      m_c = e.new_c;
      m_regs[opa] = e.new_reg;
    end
  endtask

  // Downstream ALU: in0 + in1 + cin for ADD, {cin, in0} for PASS, 5-bit rotates through carry.
  function automatic logic [4:0] alu_model(input logic [2:0] op, input logic [2:0] s0,
      input logic [1:0] s1, input logic [1:0] sc, input logic [3:0] acc, input logic c,
      input logic [3:0] rv, input logic [3:0] dv);
    logic [3:0] a, b;
    logic ci;
    int s;
    case (s0)
      ALU_IN0_ACC:      a = acc;
      ALU_IN0_ACC_INV:  a = ~acc;
      ALU_IN0_REG:      a = rv;
      ALU_IN0_REG_INV:  a = ~rv;
      ALU_IN0_DATA:     a = dv;
      ALU_IN0_DATA_INV: a = ~dv;
      default:          a = 4'h0;
    endcase
    case (s1)
      ALU_IN1_ACC:     b = acc;
      ALU_IN1_ONE:     b = 4'h1;
      ALU_IN1_ONE_INV: b = 4'hE;
      default:         b = 4'h0;
    endcase
    case (sc)
      ALU_CIN_CARRY:     ci = c;
      ALU_CIN_CARRY_INV: ci = ~c;
      ALU_CIN_ZERO:      ci = 1'b0;
      default:           ci = 1'b1;
    endcase
    s = a + b + ci;
    case (op)
      ALU_OP_PASS: return {ci, a};
      ALU_OP_ADD:  return s[4:0];
      ALU_OP_ROL:  return {a[3], a[2:0], ci};
      ALU_OP_ROR:  return {a[0], ci, a[3:1]};
      default:     return 5'h1F;
    endcase
  endfunction

  task automatic run(input logic [3:0] opr, input logic [3:0] opa);
    exp_t e;
    predict(opr, opa, e);
    sb.push_back(e);
    for (int p = 0; p < 8; p++) begin
      rom_data = (p == 3) ? opr : (p == 4) ? opa : 4'($urandom);
      @(negedge clock);
    end
  endtask

  // Drives an instruction up to X2, then pulls reset so it never completes.
  task automatic abort_insn(input logic [3:0] opr, input logic [3:0] opa);
    for (int p = 0; p < 6; p++) begin
      rom_data = (p == 3) ? opr : (p == 4) ? opa : 4'($urandom);
      @(negedge clock);
    end
    reset_n = 1'b0;
    m_second = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Monitor: per-cycle phase/pulse checks, and a scoreboard pop at each X3.
  initial begin : monitor
    int mph;
    logic first_after;
    logic [18:0] sel_x1, sel_now;
    logic [4:0] res;
    exp_t e;
    mph = 0;
    first_after = 1'b0;
    sel_x1 = '0;
    forever begin
      @(posedge clock);
      #2;
      sel_now = {alu_op, alu_in0_sel, alu_in1_sel, alu_cin_sel, reg_src, imm, reg_addr};
      if (!reset_n) begin
        mph = 0;
        first_after = 1'b1;
        check("rst_phase", 32'(phase), 32'(PH_A1));
        check("rst_sync", 32'(sync), 32'd1);
        check("rst_strobes", 32'({acc_we, carry_we, reg_we, pc_inc, pc_load}), 32'd0);
        continue;
      end
      mph = (mph + 1) % 8;
      check("phase", 32'(phase), 32'(mph));
      check("sync", 32'(sync), 32'(mph == 0));
      check("pc_inc", 32'(pc_inc), 32'(mph == 4));
      if (first_after) begin
        first_after = 1'b0;
        check("nop_selects", 32'({alu_op, alu_in0_sel, alu_in1_sel, alu_cin_sel}),
              32'({ALU_OP_PASS, ALU_IN0_ACC, ALU_IN1_ACC, ALU_CIN_CARRY}));
      end
      if (mph != 7) check("idle_strobes", 32'({acc_we, carry_we, reg_we, pc_load}), 32'd0);
      if (mph == 5) sel_x1 = sel_now;
      if (mph == 6 || mph == 7) check("sel_stable", 32'(sel_now), 32'(sel_x1));
      if (mph == 7) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check("pc_load", 32'(pc_load), 32'(e.pcl));
          check("acc_we", 32'(acc_we), 32'(e.awe));
          check("carry_we", 32'(carry_we), 32'(e.cwe));
          check("reg_we", 32'(reg_we), 32'(e.rwe));
          if (e.pcl) check("pc_target", 32'(pc_target), 32'(e.tgt));
          if (!e.pcl && (e.opr inside {4'h6, 4'h8, 4'h9, 4'hA, 4'hB}))
            check("reg_addr", 32'(reg_addr), 32'(e.opa));
          res = alu_model(alu_op, alu_in0_sel, alu_in1_sel, alu_cin_sel, e.pre_acc, e.pre_c,
                          e.pre_reg, imm);
          if (e.awe) check("acc_value", 32'(res[3:0]), 32'(e.new_acc));
          if (e.cwe) check("carry_value", 32'(res[4]), 32'(e.new_c));
          if (e.rwe) check("reg_value", 32'(reg_src ? e.pre_acc : res[3:0]), 32'(e.new_reg));
        end
      end
    end
  end

  // Stimulus: directed sequence, one aborted instruction, then random programs.
  initial begin : stimulus
    m_acc = 4'($urandom);
    m_c = 1'($urandom);
    for (int i = 0; i < 16; i++) m_regs[i] = 4'($urandom);
    m_second = 1'b0;
    m_jun_opa = 4'h0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    run(4'h8, 4'h3);
    run(4'hB, 4'h5);
    run(4'h4, 4'hA);
    run(4'h7, 4'hC);
    run(4'hF, 4'h6);
    run(4'hF, 4'h7);
    for (int k = 0; k < 16; k++) run(4'hF, 4'(k));
    run(4'h6, 4'h2);
    run(4'h9, 4'h1);
    run(4'hD, 4'h9);
    run(4'hA, 4'h2);
    run(4'h0, 4'h0);
    abort_insn(4'h8, 4'h2);
    for (int i = 0; i < 250; i++) begin
      if (i == 120) abort_insn(4'($urandom), 4'($urandom));
      run(4'($urandom), 4'($urandom));
    end
    run(4'h0, 4'h0);
    repeat (2) @(negedge clock);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
